// File: rtl/rr_select_arbiter_if.sv
// Grant bus between requesters and the round-robin arbiter.
// The master side raises requests and signals completion; the slave side
// (the arbiter) returns the grant and the timeout pulse.
interface rr_select_arbiter_if;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt_valid,
        output gnt_idx,
        output gnt,
        output timeout
    );
endinterface

// File: rtl/rr_select_arbiter.sv
// Eight-way round-robin arbiter with a bounded hold time.
// IDLE picks the first requester at or after ptr, GRANT holds that choice
// until done or HOLD_MAX cycles elapse, RELEASE inserts a one-cycle dead gap.
module rr_select_arbiter #(
    parameter int unsigned HOLD_MAX = 16  // legal range 2..255
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_select_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] gnt_idx, gnt_idx_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       timeout_q, timeout_nxt;

    logic       sel_found;
    logic [2:0] sel_idx;

    // Round-robin search: first set request bit at ptr, ptr+1, ... (mod 8).
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // a default first, so no path leaves a value unassigned (no latch).
        sel_found = 1'b0;
        sel_idx   = ptr;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] cand;
            cand = ptr + 3'(i);
            if (!sel_found && bus.req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Next-state logic: arbitration in IDLE, hold/timeout in GRANT, gap in RELEASE.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_idx_nxt  = gnt_idx;
        hold_cnt_nxt = hold_cnt;
        timeout_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    gnt_idx_nxt  = sel_idx;
                    hold_cnt_nxt = 8'd0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                hold_cnt_nxt = hold_cnt + 8'd1;
                if (bus.done) begin
                    // done wins over a coinciding hold limit: no timeout pulse
                    state_nxt = RELEASE;
                    ptr_nxt   = gnt_idx + 3'd1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = RELEASE;
                    ptr_nxt     = gnt_idx + 3'd1;
                    timeout_nxt = 1'b1;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values of the others.
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt_idx   <= 3'd0;
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt_idx   <= gnt_idx_nxt;
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Grant outputs decode straight from the state, so reset drops them at once.
    assign bus.gnt_valid = (state == GRANT);
    assign bus.gnt_idx   = gnt_idx;
    assign bus.gnt       = bus.gnt_valid ? (8'b1 << gnt_idx) : 8'b0;
    assign bus.timeout   = timeout_q;

endmodule

// File: doc/rr_select_arbiter.md
RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 16: the maximum number of cycles one grant may be held, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 8 bits: request lines; bit i is requester i.
REQ-005 SHALL have port done, input, 1 bit: the granted requester has finished; sampled only in GRANT.
REQ-006 SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-007 SHALL have port gnt_idx, output, 3 bits: binary index of the granted requester.
REQ-008 SHALL have port gnt, output, 8 bits: one-hot grant; equals the 3-to-8 decode of gnt_idx when gnt_valid=1, else 0.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by HOLD_MAX.

Function
REQ-010 SHALL implement an FSM with states IDLE, GRANT and RELEASE.
REQ-011 SHALL keep a 3-bit round-robin pointer ptr, the highest-priority index for the next arbitration.
REQ-012 IDLE: if req!=0 at a clock edge, SHALL select the first set bit searching ptr, ptr+1, ..., ptr+7 (mod 8), load gnt_idx, and enter GRANT.
REQ-013 IDLE with req==0 SHALL remain in IDLE with gnt_valid=0.
REQ-014 Latency: req sampled at edge k in IDLE SHALL give gnt_valid=1 immediately after edge k (one cycle).
REQ-015 GRANT SHALL hold gnt_idx, gnt and gnt_valid=1 constant; changes on req (including the granted bit dropping) SHALL be ignored.
REQ-016 GRANT SHALL count cycles in an 8-bit hold counter, cleared on entry to GRANT.
REQ-017 GRANT with done=1 at an edge SHALL go to RELEASE; with done=0 and the hold counter at HOLD_MAX-1, SHALL go to RELEASE and assert timeout for exactly the RELEASE cycle.
REQ-018 On done=1 in the same cycle as the timeout condition, done SHALL take precedence: no timeout pulse.
REQ-019 On leaving GRANT, ptr SHALL become gnt_idx+1 mod 8 (7 wraps to 0).
REQ-020 RELEASE SHALL last exactly one cycle with gnt_valid=0 and gnt=0, then go to IDLE; this one-cycle dead gap is mandatory between consecutive grants.
REQ-021 gnt_idx SHALL retain its last value outside GRANT; consumers qualify it with gnt_valid.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, ptr=0, gnt_idx=0, hold counter=0, gnt_valid=0, gnt=0 and timeout=0.
REQ-024 Reset asserted during GRANT SHALL drop the grant asynchronously; after release, arbitration SHALL restart from ptr=0.
REQ-025 The first edge after rst_n rises SHALL be a normal IDLE evaluation.

Verification
REQ-026 Single request: after reset, req=8'h10, done after 3 cycles -> gnt_idx=4, gnt=8'h10 one cycle after req, RELEASE gap, then ptr=5.
REQ-027 Fairness with all requesting: req=8'hFF held, done=1 every GRANT cycle -> grant order 0,1,2,...,7,0 with one idle cycle between grants.
REQ-028 Wrap-around: ptr=6 with req=8'h21 -> gnt_idx=0 (search order 6,7,0), then ptr=1 and the next grant is 5.
REQ-029 Timeout: HOLD_MAX=16, req=8'h02, done held 0 -> gnt_valid high exactly 16 cycles, timeout pulses once, gnt=0 in RELEASE, ptr=2.
REQ-030 done and timeout coinciding on cycle 16 -> RELEASE with timeout=0.
REQ-031 Reset mid-grant: rst_n low between clock edges while gnt=8'h08 -> gnt=0 and gnt_valid=0 at once; after release with req=8'h88 -> gnt_idx=3 (ptr=0).
